// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    // Controller states: wait for operands, shift bits through the cell, present the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width for an n-bit operand; never narrower than one bit
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: d = a - b - bin, bo = borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    // Difference and borrow of a single bit position
    always_comb begin
        d  = a ^ b ^ bin;
        bo = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit unsigned subtractor, diff = a - b - bin, LSB first, one bit per clock.
// Optional build macro SERIAL_SUB_SAT_EN: clamp diff to zero when the final borrow is set.
module serial_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout
);
    import serial_sub_pkg::*;

    localparam int            CW   = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  diff_sr;
    logic          borrow;
    logic [CW-1:0] count;
    logic          d;
    logic          bo;
    logic [N-1:0]  diff_next;
    logic [N-1:0]  diff_final;

    full_sub u_cell (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (borrow),
        .d   (d),
        .bo  (bo)
    );

    // New result bit enters at the MSB so that after N shifts bit 0 sits at the LSB
    always_comb begin
        diff_next = (diff_sr >> 1) | (N'(d) << (N - 1));
    end

    // Result presented in DONE: wrap-around, or clamped to zero on underflow when saturating
    always_comb begin
`ifdef SERIAL_SUB_SAT_EN
        diff_final = bo ? '0 : diff_next;
`else
        diff_final = diff_next;
`endif
    end

    // Controller, operand/result shift registers, borrow flop and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            diff_sr   <= '0;
            borrow    <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        diff_sr  <= '0;
                        borrow   <= bin;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff_sr <= diff_next;
                    borrow  <= bo;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        diff      <= diff_final;
                        bout      <= bo;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: N=8 instance with a result scoreboard, plus an N=1 instance.
module tb_serial_sub;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] diff;
        logic         bout;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, bin, bout;
    logic [N-1:0] a, b, diff;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, bin1, bout1;
    logic [0:0]   a1, b1, diff1;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sbq[$];

    serial_sub #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
    );

    serial_sub #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .bout(bout1)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference result for the N-bit build
    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
        logic [N:0] full;
        exp_t       e;
        full   = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
        e.bout = full[N];
        e.diff = full[N-1:0];
`ifdef SERIAL_SUB_SAT_EN
        if (e.bout) e.diff = '0;
`endif
        return e;
    endfunction

    // Offer one operand set, wait (bounded) for in_ready, record the accept cycle, push the expectation
    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi,
                        output bit ok, output int acc);
        int waited;
        waited = 0;
        @(negedge clk);
        a = x; b = y; bin = bi; in_valid = 1'b1;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        ok = in_ready;
        if (ok) sbq.push_back(model(x, y, bi));
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid is seen (bounded)
    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        in_valid = 1'b1; a = 8'd9; b = 8'd1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (diff !== '0)        begin errors++; $display("[TB] FAIL reset_diff got=%0d want=0", diff); end
        checks++; if (bout !== 1'b0)      begin errors++; $display("[TB] FAIL reset_bout got=%b want=0", bout); end
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (N + 2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ignored_input got=%b want=0", out_valid); end
    endtask

    task automatic test_vectors;
        logic [N-1:0] ta [4] = '{8'd200, 8'd55,  8'd0, 8'd255};
        logic [N-1:0] tb [4] = '{8'd55,  8'd200, 8'd0, 8'd255};
        logic         tc [4] = '{1'b0,   1'b0,   1'b1, 1'b0};
        bit   ok;
        int   acc, lat;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tb[i], tc[i], ok, acc);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL vec%0d_accept got=timeout want=accepted", i); end
            wait_out(lat, ok);
            checks++; if (!ok || lat != N) begin errors++; $display("[TB] FAIL vec%0d_latency got=%0d want=%0d", i, lat, N); end
            if (sbq.size() == 0) begin
                checks++; errors++; $display("[TB] FAIL vec%0d_scoreboard got=empty want=entry", i);
            end else begin
                e = sbq.pop_front();
                checks++; if (diff !== e.diff) begin errors++; $display("[TB] FAIL vec%0d_diff got=%0d want=%0d", i, diff, e.diff); end
                checks++; if (bout !== e.bout) begin errors++; $display("[TB] FAIL vec%0d_bout got=%b want=%b", i, bout, e.bout); end
            end
        end
    endtask

    task automatic test_hold;
        bit   ok;
        int   acc, lat;
        exp_t e;
        out_ready = 1'b0;
        send(8'd100, 8'd30, 1'b1, ok, acc);
        wait_out(lat, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_out_valid got=timeout want=valid"); end
        e = (sbq.size() != 0) ? sbq.pop_front() : '0;
        for (int i = 0; i < 5; i++) begin
            a = N'($urandom); b = N'($urandom); bin = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid got=%b want=1", out_valid); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL hold_in_ready got=%b want=0", in_ready); end
            checks++; if (diff !== e.diff)    begin errors++; $display("[TB] FAIL hold_diff got=%0d want=%0d", diff, e.diff); end
            checks++; if (bout !== e.bout)    begin errors++; $display("[TB] FAIL hold_bout got=%b want=%b", bout, e.bout); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL hold_release_ready got=%b want=1", in_ready); end
        repeat (N + 3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_single_result got=%b want=0", out_valid); end
    endtask

    task automatic test_abort;
        bit   ok;
        int   acc, lat;
        exp_t e;
        out_ready = 1'b1;
        send(8'd100, 8'd50, 1'b0, ok, acc);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_out_valid got=%b want=0", out_valid); end
        checks++; if (diff !== '0)        begin errors++; $display("[TB] FAIL abort_diff got=%0d want=0", diff); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL abort_in_ready got=%b want=1", in_ready); end
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        send(8'd10, 8'd3, 1'b0, ok, acc);
        wait_out(lat, ok);
        checks++; if (!ok || lat != N) begin errors++; $display("[TB] FAIL abort_next_latency got=%0d want=%0d", lat, N); end
        e = (sbq.size() != 0) ? sbq.pop_front() : '0;
        checks++; if (diff !== 8'd7)   begin errors++; $display("[TB] FAIL abort_next_diff got=%0d want=7", diff); end
        checks++; if (bout !== e.bout) begin errors++; $display("[TB] FAIL abort_next_bout got=%b want=%b", bout, e.bout); end
    endtask

    task automatic test_back_to_back;
        bit   ok;
        int   acc, lat, prev;
        exp_t e;
        out_ready = 1'b1;
        prev = -1;
        for (int i = 0; i < 20; i++) begin
            send(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), ok, acc);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b%0d_accept got=timeout want=accepted", i); end
            if (prev >= 0) begin
                checks++; if (acc - prev < N + 2) begin errors++; $display("[TB] FAIL b2b%0d_spacing got=%0d want>=%0d", i, acc - prev, N + 2); end
            end
            prev = acc;
            wait_out(lat, ok);
            checks++; if (!ok || lat != N) begin errors++; $display("[TB] FAIL b2b%0d_latency got=%0d want=%0d", i, lat, N); end
            if (sbq.size() == 0) begin
                checks++; errors++; $display("[TB] FAIL b2b%0d_scoreboard got=empty want=entry", i);
            end else begin
                e = sbq.pop_front();
                checks++; if (diff !== e.diff || bout !== e.bout) begin
                    errors++; $display("[TB] FAIL b2b%0d_result got=%0d/%b want=%0d/%b", i, diff, bout, e.diff, e.bout);
                end
            end
        end
    endtask

    task automatic test_n1;
        logic [1:0] full;
        logic       ed, eb;
        int         lat;
        bit         ok;
        out_ready1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            full = {1'b0, i[1]} - {1'b0, i[0]} - {1'b0, i[2]};
            eb   = full[1];
            ed   = full[0];
`ifdef SERIAL_SUB_SAT_EN
            if (eb) ed = 1'b0;
`endif
            @(negedge clk);
            a1 = i[1]; b1 = i[0]; bin1 = i[2]; in_valid1 = 1'b1;
            checks++; if (in_ready1 !== 1'b1) begin errors++; $display("[TB] FAIL n1_%0d_ready got=%b want=1", i, in_ready1); end
            @(posedge clk);
            @(negedge clk);
            in_valid1 = 1'b0;
            lat = 0;
            ok  = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (out_valid1) begin ok = 1'b1; break; end
            end
            checks++; if (!ok || lat != 1) begin errors++; $display("[TB] FAIL n1_%0d_latency got=%0d want=1", i, lat); end
            checks++; if (diff1 !== ed || bout1 !== eb) begin
                errors++; $display("[TB] FAIL n1_%0d_result got=%b/%b want=%b/%b", i, diff1, bout1, ed, eb);
            end
        end
    endtask

    // Absolute time bound so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0; out_ready1 = 1'b1;
        test_reset();
        test_vectors();
        test_hold();
        test_abort();
        test_back_to_back();
        test_n1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
